// File: rtl/sdram_mport_arb.sv
// -----------------------------------------------------------------------------
// sdram_mport_arb
//
// N-port front end for the single-port SDRAM controller. Port commands are
// arbitrated round-robin into one registered command slot toward the
// controller. Every granted read pushes its port index into an in-order tag
// FIFO. Each controller read response is routed to the port at the FIFO head.
// Responses that arrive with no outstanding read are accepted and discarded,
// and they set the sticky err_orphan flag.
//
// Optional build macro:
//   SDRAM_ARB_PRIO_EN  Port 0 has strict priority and is granted whenever it
//                      is eligible. The rr pointer is not updated on a port 0
//                      grant. Ports 1..N-1 round-robin among themselves.
//                      Without the macro, all ports are in one round-robin.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   p_cmd_*           per-port command channel (valid/ready/write/addr/wdata)
//   p_rsp_*           per-port read response; rdata is shared between ports
//   m_cmd_*           registered command slot toward the controller
//   m_rsp_*           read response channel from the controller
//   tag_level         number of outstanding reads
//   err_orphan        sticky flag: a response arrived with no read outstanding
// -----------------------------------------------------------------------------
module sdram_mport_arb #(
   parameter int NUM_PORTS = 4,
   parameter int ADDR_W    = 24,
   parameter int DATA_W    = 16,
   parameter int TAG_DEPTH = 8,
   localparam int PORT_W   = $clog2(NUM_PORTS)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_PORTS-1:0]          p_cmd_valid,
   output logic [NUM_PORTS-1:0]          p_cmd_ready,
   input  logic [NUM_PORTS-1:0]          p_cmd_write,
   input  logic [NUM_PORTS*ADDR_W-1:0]   p_cmd_addr,
   input  logic [NUM_PORTS*DATA_W-1:0]   p_cmd_wdata,
   output logic [NUM_PORTS-1:0]          p_rsp_valid,
   input  logic [NUM_PORTS-1:0]          p_rsp_ready,
   output logic [DATA_W-1:0]             p_rsp_rdata,
   output logic                          m_cmd_valid,
   input  logic                          m_cmd_ready,
   output logic                          m_cmd_write,
   output logic [ADDR_W-1:0]             m_cmd_addr,
   output logic [DATA_W-1:0]             m_cmd_wdata,
   input  logic                          m_rsp_valid,
   output logic                          m_rsp_ready,
   input  logic [DATA_W-1:0]             m_rsp_rdata,
   output logic [$clog2(TAG_DEPTH):0]    tag_level,
   output logic                          err_orphan
);

   localparam int TAG_AW = $clog2(TAG_DEPTH);
   localparam int LVL_W  = TAG_AW + 1;

   // Port index (base + k) mod NUM_PORTS. The sum cannot overflow PORT_W+1 bits
   // because base and k are both below NUM_PORTS.
   function automatic logic [PORT_W-1:0] wrap_add(input logic [PORT_W-1:0] base,
                                                  input int k);
      logic [PORT_W:0] sum;
      sum = {1'b0, base} + (PORT_W+1)'(k);
      if (sum >= (PORT_W+1)'(NUM_PORTS)) begin
         sum = sum - (PORT_W+1)'(NUM_PORTS);
      end else begin
         sum = sum;
      end
      return sum[PORT_W-1:0];
   endfunction

   logic [PORT_W-1:0]    tag_mem_r [TAG_DEPTH];
   logic [TAG_AW-1:0]    wr_ptr_r;
   logic [TAG_AW-1:0]    rd_ptr_r;
   logic [LVL_W-1:0]     level_r;
   logic [PORT_W-1:0]    rr_r;
   logic                 m_cmd_valid_r;
   logic                 m_cmd_write_r;
   logic [ADDR_W-1:0]    m_cmd_addr_r;
   logic [DATA_W-1:0]    m_cmd_wdata_r;
   logic                 err_orphan_r;

   logic [PORT_W-1:0]    head_s;
   logic [PORT_W-1:0]    grant_idx_s;
   logic                 grant_valid_s;
   logic [NUM_PORTS-1:0] eligible_s;
   logic                 load_en_s;
   logic                 push_s;
   logic                 pop_s;
   logic                 tag_empty_s;
   logic                 tag_full_s;
   logic                 tag_full_next_s;
   logic                 rr_upd_s;

   assign tag_empty_s     = (level_r == LVL_W'(0));
   assign tag_full_s      = (level_r == LVL_W'(TAG_DEPTH));
   assign head_s          = tag_mem_r[rd_ptr_r];
   assign pop_s           = ~tag_empty_s & m_rsp_valid & m_rsp_ready;
   // A read may take the last free tag if a response frees one on this edge.
   assign tag_full_next_s = tag_full_s & ~pop_s;
   assign eligible_s      = p_cmd_valid & (p_cmd_write | {NUM_PORTS{~tag_full_next_s}});
   assign load_en_s       = ~m_cmd_valid_r | m_cmd_ready;
   assign push_s          = load_en_s & grant_valid_s & ~p_cmd_write[grant_idx_s];

`ifdef SDRAM_ARB_PRIO_EN
   assign rr_upd_s = load_en_s & grant_valid_s & (grant_idx_s != PORT_W'(0));
`else
   assign rr_upd_s = load_en_s & grant_valid_s;
`endif

   // Grant search: the first eligible port at or after the rr pointer.
   always_comb begin
      grant_valid_s = 1'b0;
      grant_idx_s   = PORT_W'(0);
`ifdef SDRAM_ARB_PRIO_EN
      if (eligible_s[0]) begin
         grant_valid_s = 1'b1;
         grant_idx_s   = PORT_W'(0);
      end else begin
         for (int k = 0; k < NUM_PORTS; k++) begin
            if (!grant_valid_s && (wrap_add(rr_r, k) != PORT_W'(0))
                && eligible_s[wrap_add(rr_r, k)]) begin
               grant_valid_s = 1'b1;
               grant_idx_s   = wrap_add(rr_r, k);
            end else begin
               grant_valid_s = grant_valid_s;
            end
         end
      end
`else
      for (int k = 0; k < NUM_PORTS; k++) begin
         if (!grant_valid_s && eligible_s[wrap_add(rr_r, k)]) begin
            grant_valid_s = 1'b1;
            grant_idx_s   = wrap_add(rr_r, k);
         end else begin
            grant_valid_s = grant_valid_s;
         end
      end
`endif
   end

   // One-hot command accept, raised only for the granted port when the slot can load.
   always_comb begin
      p_cmd_ready = '0;
      if (load_en_s && grant_valid_s) begin
         p_cmd_ready[grant_idx_s] = 1'b1;
      end else begin
         p_cmd_ready = '0;
      end
   end

   // Response routing to the port at the tag FIFO head. With no outstanding
   // reads, responses are accepted and discarded.
   always_comb begin
      p_rsp_valid = '0;
      m_rsp_ready = 1'b1;
      if (!tag_empty_s) begin
         p_rsp_valid[head_s] = m_rsp_valid;
         m_rsp_ready         = p_rsp_ready[head_s];
      end else begin
         m_rsp_ready = 1'b1;
      end
   end

   assign p_rsp_rdata = m_rsp_rdata;

   // Command slot register and round-robin pointer.
   always_ff @(posedge clk) begin
      if (rst) begin
         m_cmd_valid_r <= 1'b0;
         m_cmd_write_r <= 1'b0;
         m_cmd_addr_r  <= '0;
         m_cmd_wdata_r <= '0;
         rr_r          <= PORT_W'(0);
      end else begin
         if (load_en_s) begin
            m_cmd_valid_r <= grant_valid_s;
            if (grant_valid_s) begin
               m_cmd_write_r <= p_cmd_write[grant_idx_s];
               m_cmd_addr_r  <= p_cmd_addr[int'(grant_idx_s)*ADDR_W +: ADDR_W];
               m_cmd_wdata_r <= p_cmd_wdata[int'(grant_idx_s)*DATA_W +: DATA_W];
            end
         end
         if (rr_upd_s) begin
            rr_r <= wrap_add(grant_idx_s, 1);
         end
      end
   end

   // Tag storage. Entries need no reset because the pointers define validity.
   always_ff @(posedge clk) begin
      if (push_s) begin
         tag_mem_r[wr_ptr_r] <= grant_idx_s;
      end
   end

   // Tag FIFO pointers, level and the sticky orphan flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r     <= '0;
         rd_ptr_r     <= '0;
         level_r      <= '0;
         err_orphan_r <= 1'b0;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + TAG_AW'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + TAG_AW'(1);
         end
         case ({push_s, pop_s})
            2'b10:   level_r <= level_r + LVL_W'(1);
            2'b01:   level_r <= level_r - LVL_W'(1);
            default: level_r <= level_r;
         endcase
         if (tag_empty_s && m_rsp_valid) begin
            err_orphan_r <= 1'b1;
         end
      end
   end

   assign m_cmd_valid = m_cmd_valid_r;
   assign m_cmd_write = m_cmd_write_r;
   assign m_cmd_addr  = m_cmd_addr_r;
   assign m_cmd_wdata = m_cmd_wdata_r;
   assign tag_level   = level_r;
   assign err_orphan  = err_orphan_r;

endmodule

// File: tb/tb_sdram_mport_arb.sv
// -----------------------------------------------------------------------------
// tb_sdram_mport_arb
//
// Self-checking bench for sdram_mport_arb with default parameters. Expected
// controller commands and expected port responses are queued as stimulus is
// applied. A negedge monitor pops and compares them whenever a handshake is
// observed. Directed checks cover the grant pattern, slot hold, tag-full
// blocking, in-order routing, orphan responses and reset.
// -----------------------------------------------------------------------------
module tb_sdram_mport_arb;

   localparam int NP = 4;
   localparam int AW = 24;
   localparam int DW = 16;
   localparam int TD = 8;

   typedef struct {
      logic          write;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } cmd_t;

   typedef struct {
      logic [NP-1:0] mask;
      logic [DW-1:0] data;
   } rsp_t;

   logic               clk = 1'b0;
   logic               rst;
   logic [NP-1:0]      p_cmd_valid;
   logic [NP-1:0]      p_cmd_ready;
   logic [NP-1:0]      p_cmd_write;
   logic [NP*AW-1:0]   p_cmd_addr;
   logic [NP*DW-1:0]   p_cmd_wdata;
   logic [NP-1:0]      p_rsp_valid;
   logic [NP-1:0]      p_rsp_ready;
   logic [DW-1:0]      p_rsp_rdata;
   logic               m_cmd_valid;
   logic               m_cmd_ready;
   logic               m_cmd_write;
   logic [AW-1:0]      m_cmd_addr;
   logic [DW-1:0]      m_cmd_wdata;
   logic               m_rsp_valid;
   logic               m_rsp_ready;
   logic [DW-1:0]      m_rsp_rdata;
   logic [$clog2(TD):0] tag_level;
   logic               err_orphan;

   cmd_t exp_cmd_q[$];
   rsp_t exp_rsp_q[$];
   cmd_t mon_cmd;
   rsp_t mon_rsp;
   int   n_checks = 0;
   int   n_fail   = 0;

   sdram_mport_arb #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .TAG_DEPTH(TD)) dut (
      .clk         (clk),
      .rst         (rst),
      .p_cmd_valid (p_cmd_valid),
      .p_cmd_ready (p_cmd_ready),
      .p_cmd_write (p_cmd_write),
      .p_cmd_addr  (p_cmd_addr),
      .p_cmd_wdata (p_cmd_wdata),
      .p_rsp_valid (p_rsp_valid),
      .p_rsp_ready (p_rsp_ready),
      .p_rsp_rdata (p_rsp_rdata),
      .m_cmd_valid (m_cmd_valid),
      .m_cmd_ready (m_cmd_ready),
      .m_cmd_write (m_cmd_write),
      .m_cmd_addr  (m_cmd_addr),
      .m_cmd_wdata (m_cmd_wdata),
      .m_rsp_valid (m_rsp_valid),
      .m_rsp_ready (m_rsp_ready),
      .m_rsp_rdata (m_rsp_rdata),
      .tag_level   (tag_level),
      .err_orphan  (err_orphan)
   );

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_cmd(input int p, input logic v, input logic w,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
      p_cmd_valid[p]         = v;
      p_cmd_write[p]         = w;
      p_cmd_addr[p*AW +: AW] = a;
      p_cmd_wdata[p*DW +: DW] = d;
   endtask

   task automatic exp_cmd(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      cmd_t c;
      c.write = w;
      c.addr  = a;
      c.wdata = d;
      exp_cmd_q.push_back(c);
   endtask

   task automatic exp_rsp(input logic [NP-1:0] m, input logic [DW-1:0] d);
      rsp_t r;
      r.mask = m;
      r.data = d;
      exp_rsp_q.push_back(r);
   endtask

   // Wait, within a cycle budget, until the monitor has consumed all expectations.
   task automatic wait_drain(input int budget);
      int n = 0;
      while ((exp_cmd_q.size() != 0 || exp_rsp_q.size() != 0) && n < budget) begin
         @(negedge clk);
         #1;
         n++;
      end
      check_eq("drain_cmd", 32'(exp_cmd_q.size()), 32'd0);
      check_eq("drain_rsp", 32'(exp_rsp_q.size()), 32'd0);
      tick();
   endtask

   // Scoreboard monitor: compare every controller command and port response handshake.
   always @(negedge clk) begin
      if (m_cmd_valid === 1'b1 && m_cmd_ready === 1'b1) begin
         if (exp_cmd_q.size() == 0) begin
            check_eq("cmd_unexpected", 32'(m_cmd_addr), 32'hFFFF_FFFF);
         end else begin
            mon_cmd = exp_cmd_q.pop_front();
            check_eq("cmd_write", 32'(m_cmd_write), 32'(mon_cmd.write));
            check_eq("cmd_addr", 32'(m_cmd_addr), 32'(mon_cmd.addr));
            if (mon_cmd.write) begin
               check_eq("cmd_wdata", 32'(m_cmd_wdata), 32'(mon_cmd.wdata));
            end
         end
      end
      if ((p_rsp_valid & p_rsp_ready) != '0) begin
         if (exp_rsp_q.size() == 0) begin
            check_eq("rsp_unexpected", 32'(p_rsp_valid), 32'd0);
         end else begin
            mon_rsp = exp_rsp_q.pop_front();
            check_eq("rsp_port", 32'(p_rsp_valid), 32'(mon_rsp.mask));
            check_eq("rsp_data", 32'(p_rsp_rdata), 32'(mon_rsp.data));
         end
      end
   end

   // Hard time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "time limit reached");
   end

   initial begin
      rst         = 1'b1;
      p_cmd_valid = '0;
      p_cmd_write = '0;
      p_cmd_addr  = '0;
      p_cmd_wdata = '0;
      p_rsp_ready = '1;
      m_cmd_ready = 1'b0;
      m_rsp_valid = 1'b0;
      m_rsp_rdata = '0;
      repeat (3) tick();
      rst = 1'b0;

      // Reset state
      @(negedge clk);
      check_eq("rst_m_cmd_valid", 32'(m_cmd_valid), 32'd0);
      check_eq("rst_m_cmd_addr", 32'(m_cmd_addr), 32'd0);
      check_eq("rst_tag_level", 32'(tag_level), 32'd0);
      check_eq("rst_err_orphan", 32'(err_orphan), 32'd0);
      check_eq("rst_p_rsp_valid", 32'(p_rsp_valid), 32'd0);
      check_eq("rst_m_rsp_ready", 32'(m_rsp_ready), 32'd1);
      tick();

`ifndef SDRAM_ARB_PRIO_EN
      // Round robin: all ports write continuously, grants rotate 0,1,2,3
      m_cmd_ready = 1'b1;
      for (int r = 0; r < 3; r++) begin
         for (int p = 0; p < NP; p++) begin
            exp_cmd(1'b1, 24'h10_0000 + 24'(p), 16'hA000 + 16'(p));
         end
      end
      for (int p = 0; p < NP; p++) begin
         set_cmd(p, 1'b1, 1'b1, 24'h10_0000 + 24'(p), 16'hA000 + 16'(p));
      end
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         check_eq("rr_ready", 32'(p_cmd_ready), 32'd1 << (k % 4));
         tick();
      end
      for (int p = 0; p < NP; p++) begin
         set_cmd(p, 1'b0, 1'b0, 24'h0, 16'h0);
      end
      wait_drain(20);
`else
      // Strict priority: port 0 wins over port 2 until it drops
      m_cmd_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         exp_cmd(1'b1, 24'h80_0000, 16'h8000);
      end
      exp_cmd(1'b1, 24'h82_0000, 16'h8200);
      set_cmd(0, 1'b1, 1'b1, 24'h80_0000, 16'h8000);
      set_cmd(2, 1'b1, 1'b1, 24'h82_0000, 16'h8200);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check_eq("prio_p0", 32'(p_cmd_ready), 32'h1);
         tick();
      end
      set_cmd(0, 1'b0, 1'b0, 24'h0, 16'h0);
      @(negedge clk);
      check_eq("prio_p2", 32'(p_cmd_ready), 32'h4);
      tick();
      set_cmd(2, 1'b0, 1'b0, 24'h0, 16'h0);
      wait_drain(10);
`endif

      // Held slot: port 2 read stalls 5 cycles, no other grant meanwhile
      m_cmd_ready = 1'b0;
      exp_cmd(1'b0, 24'h00_1234, 16'h0000);
      exp_cmd(1'b1, 24'h00_0ABC, 16'h5555);
      set_cmd(2, 1'b1, 1'b0, 24'h00_1234, 16'h0000);
      @(negedge clk);
      check_eq("hold_grant2", 32'(p_cmd_ready), 32'h4);
      tick();
      set_cmd(2, 1'b0, 1'b0, 24'h0, 16'h0);
      set_cmd(0, 1'b1, 1'b1, 24'h00_0ABC, 16'h5555);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check_eq("hold_valid", 32'(m_cmd_valid), 32'd1);
         check_eq("hold_addr", 32'(m_cmd_addr), 32'h1234);
         check_eq("hold_write", 32'(m_cmd_write), 32'd0);
         check_eq("hold_no_grant", 32'(p_cmd_ready), 32'd0);
         tick();
      end
      m_cmd_ready = 1'b1;
      @(negedge clk);
      check_eq("b2b_grant0", 32'(p_cmd_ready), 32'h1);
      tick();
      set_cmd(0, 1'b0, 1'b0, 24'h0, 16'h0);
      wait_drain(10);
      @(negedge clk);
      check_eq("hold_level", 32'(tag_level), 32'd1);
      tick();
      exp_rsp(4'b0100, 16'hBEEF);
      m_rsp_valid = 1'b1;
      m_rsp_rdata = 16'hBEEF;
      @(negedge clk);
      check_eq("beef_port", 32'(p_rsp_valid), 32'h4);
      check_eq("beef_data", 32'(p_rsp_rdata), 32'hBEEF);
      tick();
      m_rsp_valid = 1'b0;
      wait_drain(5);
      @(negedge clk);
      check_eq("beef_level", 32'(tag_level), 32'd0);
      tick();

      // Tag FIFO full: 9th read blocked, write passes, pop releases the read
      for (int k = 0; k < 8; k++) begin
         exp_cmd(1'b0, 24'h00_0100, 16'h0000);
      end
      exp_cmd(1'b1, 24'h00_3000, 16'h3333);
      exp_cmd(1'b0, 24'h00_0100, 16'h0000);
      set_cmd(1, 1'b1, 1'b0, 24'h00_0100, 16'h0000);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         check_eq("full_rd_grant", 32'(p_cmd_ready), 32'h2);
         tick();
      end
      set_cmd(3, 1'b1, 1'b1, 24'h00_3000, 16'h3333);
      @(negedge clk);
      check_eq("full_level8", 32'(tag_level), 32'd8);
      check_eq("full_wr_pass", 32'(p_cmd_ready), 32'h8);
      tick();
      set_cmd(3, 1'b0, 1'b0, 24'h0, 16'h0);
      @(negedge clk);
      check_eq("full_rd_blocked", 32'(p_cmd_ready), 32'h0);
      tick();
      exp_rsp(4'b0010, 16'h7000);
      m_rsp_valid = 1'b1;
      m_rsp_rdata = 16'h7000;
      @(negedge clk);
      check_eq("full_pop_grant", 32'(p_cmd_ready), 32'h2);
      tick();
      m_rsp_valid = 1'b0;
      set_cmd(1, 1'b0, 1'b0, 24'h0, 16'h0);
      @(negedge clk);
      check_eq("full_push_pop_level", 32'(tag_level), 32'd8);
      tick();
      for (int k = 1; k <= 8; k++) begin
         exp_rsp(4'b0010, 16'h7000 + 16'(k));
         m_rsp_valid = 1'b1;
         m_rsp_rdata = 16'h7000 + 16'(k);
         tick();
      end
      m_rsp_valid = 1'b0;
      wait_drain(5);
      @(negedge clk);
      check_eq("full_drained_level", 32'(tag_level), 32'd0);
      tick();

      // In-order routing: reads from ports 3, 0, 1; port 0 stalls its response
      exp_cmd(1'b0, 24'h00_0300, 16'h0000);
      exp_cmd(1'b0, 24'h00_0400, 16'h0000);
      exp_cmd(1'b0, 24'h00_0500, 16'h0000);
      set_cmd(3, 1'b1, 1'b0, 24'h00_0300, 16'h0000);
      @(negedge clk);
      check_eq("ord_grant3", 32'(p_cmd_ready), 32'h8);
      tick();
      set_cmd(3, 1'b0, 1'b0, 24'h0, 16'h0);
      set_cmd(0, 1'b1, 1'b0, 24'h00_0400, 16'h0000);
      @(negedge clk);
      check_eq("ord_grant0", 32'(p_cmd_ready), 32'h1);
      tick();
      set_cmd(0, 1'b0, 1'b0, 24'h0, 16'h0);
      set_cmd(1, 1'b1, 1'b0, 24'h00_0500, 16'h0000);
      @(negedge clk);
      check_eq("ord_grant1", 32'(p_cmd_ready), 32'h2);
      tick();
      set_cmd(1, 1'b0, 1'b0, 24'h0, 16'h0);
      wait_drain(5);
      exp_rsp(4'b1000, 16'h1111);
      exp_rsp(4'b0001, 16'h2222);
      exp_rsp(4'b0010, 16'h3333);
      p_rsp_ready = 4'b1110;
      m_rsp_valid = 1'b1;
      m_rsp_rdata = 16'h1111;
      @(negedge clk);
      check_eq("ord_rsp3", 32'(p_rsp_valid), 32'h8);
      check_eq("ord_rsp3_ready", 32'(m_rsp_ready), 32'd1);
      tick();
      m_rsp_rdata = 16'h2222;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check_eq("ord_stall_valid", 32'(p_rsp_valid), 32'h1);
         check_eq("ord_stall_ready", 32'(m_rsp_ready), 32'd0);
         tick();
      end
      p_rsp_ready = 4'b1111;
      @(negedge clk);
      check_eq("ord_rsp0_ready", 32'(m_rsp_ready), 32'd1);
      tick();
      m_rsp_rdata = 16'h3333;
      @(negedge clk);
      check_eq("ord_rsp1", 32'(p_rsp_valid), 32'h2);
      tick();
      m_rsp_valid = 1'b0;
      wait_drain(5);
      @(negedge clk);
      check_eq("ord_level", 32'(tag_level), 32'd0);
      tick();

      // Orphan response: drained, not routed, sticky error
      m_rsp_valid = 1'b1;
      m_rsp_rdata = 16'hDEAD;
      @(negedge clk);
      check_eq("orph_ready", 32'(m_rsp_ready), 32'd1);
      check_eq("orph_no_valid", 32'(p_rsp_valid), 32'd0);
      check_eq("orph_pre", 32'(err_orphan), 32'd0);
      tick();
      m_rsp_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check_eq("orph_sticky", 32'(err_orphan), 32'd1);
         tick();
      end

      // Reset mid-burst: held write and an outstanding read are dropped
      exp_cmd(1'b0, 24'h00_0600, 16'h0000);
      set_cmd(2, 1'b1, 1'b0, 24'h00_0600, 16'h0000);
      @(negedge clk);
      check_eq("mid_grant2", 32'(p_cmd_ready), 32'h4);
      tick();
      set_cmd(2, 1'b0, 1'b0, 24'h0, 16'h0);
      set_cmd(1, 1'b1, 1'b1, 24'h00_0700, 16'h7777);
      @(negedge clk);
      check_eq("mid_grant1", 32'(p_cmd_ready), 32'h2);
      tick();
      m_cmd_ready = 1'b0;
      set_cmd(3, 1'b1, 1'b1, 24'h00_0800, 16'h8888);
      @(negedge clk);
      check_eq("mid_held", 32'(m_cmd_valid), 32'd1);
      check_eq("mid_level", 32'(tag_level), 32'd1);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      exp_cmd_q.delete();
      exp_rsp_q.delete();
      @(negedge clk);
      check_eq("mrst_valid", 32'(m_cmd_valid), 32'd0);
      check_eq("mrst_write", 32'(m_cmd_write), 32'd0);
      check_eq("mrst_addr", 32'(m_cmd_addr), 32'd0);
      check_eq("mrst_wdata", 32'(m_cmd_wdata), 32'd0);
      check_eq("mrst_level", 32'(tag_level), 32'd0);
      check_eq("mrst_orphan", 32'(err_orphan), 32'd0);
      check_eq("mrst_rsp_valid", 32'(p_rsp_valid), 32'd0);
      check_eq("mrst_rr", 32'(p_cmd_ready), 32'h2);
      tick();
      p_cmd_valid = '0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sdram_mport_arb.md
Name: sdram_mport_arb

Overview:
- N-port front end for the single-port SDRAM controller. Lets several masters share one controller command/response channel.
- Round-robin arbitration over port commands into one registered command slot toward the controller.
- Tracks outstanding reads in an in-order tag FIFO, and routes each controller read response back to the port that issued the read.
- Sits between the system masters and the controller's cmd_*/rsp_* interface.

Parameters:
- NUM_PORTS, 4, number of master ports (2..8).
- ADDR_W, 24, flat command address width (row+col+bank, same packing as the controller).
- DATA_W, 16, data width.
- TAG_DEPTH, 8, depth of the outstanding-read tag FIFO (power of 2, >=2).
- PORT_W, $clog2(NUM_PORTS), width of a port index (derived; not overridden).

Ports:
- clk  in  1  system clock, also the controller clock.
- rst  in  1  synchronous reset, active-high.
- p_cmd_valid  in  NUM_PORTS  per-port command request.
- p_cmd_ready  out  NUM_PORTS  per-port command accept.
- p_cmd_write  in  NUM_PORTS  1 = write, 0 = read.
- p_cmd_addr  in  NUM_PORTS*ADDR_W  per-port address; port i occupies bits [i*ADDR_W +: ADDR_W].
- p_cmd_wdata  in  NUM_PORTS*DATA_W  per-port write data, same slicing.
- p_rsp_valid  out  NUM_PORTS  read data valid, routed to the owning port.
- p_rsp_ready  in  NUM_PORTS  per-port response accept.
- p_rsp_rdata  out  DATA_W  read data; shared, qualified by p_rsp_valid.
- m_cmd_valid  out  1  command to controller.
- m_cmd_ready  in  1  controller accept.
- m_cmd_write  out  1  write flag.
- m_cmd_addr  out  ADDR_W  address.
- m_cmd_wdata  out  DATA_W  write data.
- m_rsp_valid  in  1  controller read response valid.
- m_rsp_ready  out  1  response accept to controller.
- m_rsp_rdata  in  DATA_W  controller read data.
- tag_level  out  $clog2(TAG_DEPTH)+1  outstanding reads.
- err_orphan  out  1  sticky: a response arrived with no outstanding read.

Behaviour:
- Reset: m_cmd_valid=0, m_cmd_write/addr/wdata=0, tag FIFO empty, tag_level=0, rr pointer=0 (port 0 has highest priority first), err_orphan=0.
- Reset mid-transfer drops the held command and all tags.
- Command slot:
  - One output register. load_en = !m_cmd_valid | m_cmd_ready.
  - Eligible port i: p_cmd_valid[i] & (p_cmd_write[i] | !tag_full_next).
  - When load_en is set, grant the first eligible port, searching from rr pointer upward with wrap at NUM_PORTS-1 -> 0. Exactly one p_cmd_ready bit is high, combinationally, only for that port.
  - On grant, the slot captures write/addr/wdata on the next edge and m_cmd_valid=1. Latency is 1 cycle from port handshake to m_cmd_valid.
  - rr pointer becomes grant+1 (mod NUM_PORTS).
  - The slot holds stable while m_cmd_valid & !m_cmd_ready.
  - Back-to-back: a consume and a new load in the same cycle give full throughput.
- Tag FIFO:
  - Push the granted port index when a read is granted.
  - tag_full_next accounts for a same-cycle pop: reads are blocked only if the FIFO is full and no pop occurs that cycle.
  - Writes are never blocked by the FIFO.
- Response routing, FIFO non-empty:
  - p_rsp_valid[head] = m_rsp_valid, all others 0.
  - p_rsp_rdata = m_rsp_rdata.
  - m_rsp_ready = p_rsp_ready[head].
  - Pop on m_rsp_valid & m_rsp_ready.
- Response routing, FIFO empty:
  - All p_rsp_valid=0 and m_rsp_ready=1, so the response is drained and discarded.
  - If m_rsp_valid, set err_orphan. It clears only on rst.
- Simultaneous push and pop: level unchanged, both pointers advance.
- Pointers wrap modulo TAG_DEPTH.
- Responses are strictly in order; the controller returns reads in issue order.

Optional Feature:
- SDRAM_ARB_PRIO_EN defined:
  - Port 0 is strict high priority. If port 0 is eligible it is granted regardless of the rr pointer, and the rr pointer is not updated.
  - Ports 1..N-1 round-robin among themselves when port 0 is not requesting.
- Not defined: pure round-robin across all ports, as above.

Test Plan:
- All 4 ports request writes continuously, m_cmd_ready=1 -> m_cmd_addr sequence is port 0,1,2,3,0,… addresses, one per cycle, each p_cmd_ready pulsing once per 4 cycles.
- Port 2 issues read addr 0x00_1234; m_cmd_ready held 0 for 5 cycles -> m_cmd_* stable for all 5 cycles, no other grant. The controller then returns 0xBEEF -> p_rsp_valid=4'b0100, p_rsp_rdata=0xBEEF.
- TAG_DEPTH=8: 8 reads from port 1 with no responses -> tag_level=8. A 9th read is held, not granted, while a port 3 write is granted. A response pops -> 9th read granted the same cycle.
- Reads from ports 3, 0, 1; responses 0x1111, 0x2222, 0x3333; p_rsp_ready[0] low 3 cycles -> 0x1111 to port 3. m_rsp_ready=0 while port 0 stalls. 0x2222 to port 0, then 0x3333 to port 1.
- m_rsp_valid pulse with tag_level=0 -> m_rsp_ready=1, no p_rsp_valid, err_orphan=1 until rst.
- With SDRAM_ARB_PRIO_EN, ports 0 and 2 both requesting for 4 cycles -> 4 port 0 grants. Port 0 drops -> port 2 granted. Assert rst mid-burst -> all outputs at reset values next cycle.
